// File: rtl/cv32e40p_obi_mem_arbiter.sv
// cv32e40p_obi_mem_arbiter
// Shares one OBI memory port between the instruction and data interfaces.
// The address phase is arbitrated in IDLE. If the winner is not granted, it is
// latched and held in HOLD until mem_gnt_i arrives. Every accepted transaction
// records its source in an in-order FIFO. Each mem_rvalid_i is routed to the
// source at the head of that FIFO.
// Optional feature: define OBI_ARB_ROUND_ROBIN_EN for round-robin arbitration
// on contention. The default build uses fixed priority, where data beats instr.
module cv32e40p_obi_mem_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   instr_req_i,
    input  logic [ADDR_WIDTH-1:0]                  instr_addr_i,
    output logic                                   instr_gnt_o,
    output logic                                   instr_rvalid_o,
    output logic [DATA_WIDTH-1:0]                  instr_rdata_o,
    input  logic                                   data_req_i,
    input  logic                                   data_we_i,
    input  logic [DATA_WIDTH/8-1:0]                data_be_i,
    input  logic [ADDR_WIDTH-1:0]                  data_addr_i,
    input  logic [DATA_WIDTH-1:0]                  data_wdata_i,
    output logic                                   data_gnt_o,
    output logic                                   data_rvalid_o,
    output logic [DATA_WIDTH-1:0]                  data_rdata_o,
    output logic                                   mem_req_o,
    output logic                                   mem_we_o,
    output logic [DATA_WIDTH/8-1:0]                mem_be_o,
    output logic [ADDR_WIDTH-1:0]                  mem_addr_o,
    output logic [DATA_WIDTH-1:0]                  mem_wdata_o,
    input  logic                                   mem_gnt_i,
    input  logic                                   mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                  mem_rdata_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
    output logic                                   err_o
);

    localparam int BE_WIDTH  = DATA_WIDTH / 8;
    localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_WIDTH = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(MAX_OUTSTANDING);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = CNT_WIDTH'(0);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [PTR_WIDTH-1:0] PTR_LAST = PTR_WIDTH'(MAX_OUTSTANDING - 1);
    localparam logic [PTR_WIDTH-1:0] PTR_ZERO = PTR_WIDTH'(0);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE  = PTR_WIDTH'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    state_e                     state_r;
    logic                       hold_data_r;   // latched winner: 1 = data, 0 = instr
    logic [MAX_OUTSTANDING-1:0] src_fifo_r;    // per-slot source: 1 = data
    logic [PTR_WIDTH-1:0]       wr_ptr_r;
    logic [PTR_WIDTH-1:0]       rd_ptr_r;
    logic [CNT_WIDTH-1:0]       count_r;
    logic                       err_r;
`ifdef OBI_ARB_ROUND_ROBIN_EN
    logic                       last_data_r;   // last granted requester: 1 = data
`endif

    logic full_s;
    logic arb_data_s;
    logic req_s;
    logic sel_data_s;
    logic push_s;
    logic pop_s;
    logic head_data_s;

    // Arbitration: pick this cycle's winner and decide whether a request goes out.
    always_comb begin
        full_s     = (count_r == CNT_MAX);
        arb_data_s = 1'b0;
        req_s      = 1'b0;
        sel_data_s = 1'b0;
        if (data_req_i && instr_req_i) begin
`ifdef OBI_ARB_ROUND_ROBIN_EN
            arb_data_s = ~last_data_r;
`else
            arb_data_s = 1'b1;
`endif
        end else begin
            arb_data_s = data_req_i;
        end
        case (state_r)
            ST_HOLD: begin
                req_s      = ~rst_i;
                sel_data_s = hold_data_r;
            end
            ST_IDLE: begin
                req_s      = ~rst_i & ~full_s & (instr_req_i | data_req_i);
                sel_data_s = arb_data_s;
            end
            default: begin
                req_s      = 1'b0;
                sel_data_s = 1'b0;
            end
        endcase
    end

    // Output steering: memory request fields, grants and response routing.
    always_comb begin
        push_s      = req_s & mem_gnt_i;
        pop_s       = ~rst_i & mem_rvalid_i & (count_r != CNT_ZERO);
        head_data_s = src_fifo_r[rd_ptr_r];

        mem_req_o   = req_s;
        mem_we_o    = req_s & sel_data_s & data_we_i;
        if (!req_s) begin
            mem_be_o    = {BE_WIDTH{1'b0}};
            mem_addr_o  = {ADDR_WIDTH{1'b0}};
            mem_wdata_o = {DATA_WIDTH{1'b0}};
        end else if (sel_data_s) begin
            mem_be_o    = data_be_i;
            mem_addr_o  = data_addr_i;
            mem_wdata_o = data_wdata_i;
        end else begin
            mem_be_o    = {BE_WIDTH{1'b1}};
            mem_addr_o  = instr_addr_i;
            mem_wdata_o = {DATA_WIDTH{1'b0}};
        end

        instr_gnt_o    = push_s & ~sel_data_s;
        data_gnt_o     = push_s & sel_data_s;
        instr_rvalid_o = pop_s & ~head_data_s;
        data_rvalid_o  = pop_s & head_data_s;
        instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : {DATA_WIDTH{1'b0}};
        data_rdata_o   = data_rvalid_o ? mem_rdata_i : {DATA_WIDTH{1'b0}};
        outstanding_o  = count_r;
        err_o          = err_r;
    end

    // FSM: latch an ungranted winner and hold it until the memory grants.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r     <= ST_IDLE;
            hold_data_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_s && !mem_gnt_i) begin
                        state_r     <= ST_HOLD;
                        hold_data_r <= sel_data_s;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (mem_gnt_i) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Source FIFO: push on grant, pop on routed response, keep occupancy count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            src_fifo_r <= {MAX_OUTSTANDING{1'b0}};
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            count_r    <= CNT_ZERO;
        end else begin
            if (push_s) begin
                src_fifo_r[wr_ptr_r] <= sel_data_s;
                wr_ptr_r <= (wr_ptr_r == PTR_LAST) ? PTR_ZERO : wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= (rd_ptr_r == PTR_LAST) ? PTR_ZERO : rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky error: response arrived while nothing was outstanding.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_r <= 1'b0;
        end else if (mem_rvalid_i && (count_r == CNT_ZERO)) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

`ifdef OBI_ARB_ROUND_ROBIN_EN
    // Round-robin history: remember which requester was granted last.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_data_r <= 1'b0;
        end else if (push_s) begin
            last_data_r <= sel_data_s;
        end else begin
            last_data_r <= last_data_r;
        end
    end
`endif

endmodule

// File: tb/tb_cv32e40p_obi_mem_arbiter.sv
// Randomized bench for cv32e40p_obi_mem_arbiter. Its reference model holds the
// outstanding transactions as a queue of sources, plus a hold flag and a
// last-winner bit. The memory responses it expects go into a scoreboard queue.
// A separate monitor pops that queue whenever the DUT answers.
module tb_cv32e40p_obi_mem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BW   = DW / 8;
    localparam int MAXO = 2;
    localparam int CW   = $clog2(MAXO + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          instr_req_i;
    logic [AW-1:0] instr_addr_i;
    logic          instr_gnt_o;
    logic          instr_rvalid_o;
    logic [DW-1:0] instr_rdata_o;
    logic          data_req_i;
    logic          data_we_i;
    logic [BW-1:0] data_be_i;
    logic [AW-1:0] data_addr_i;
    logic [DW-1:0] data_wdata_i;
    logic          data_gnt_o;
    logic          data_rvalid_o;
    logic [DW-1:0] data_rdata_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [BW-1:0] mem_be_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_gnt_i;
    logic          mem_rvalid_i;
    logic [DW-1:0] mem_rdata_i;
    logic [CW-1:0] outstanding_o;
    logic          err_o;

    always #5 clk = ~clk;

    cv32e40p_obi_mem_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .outstanding_o(outstanding_o), .err_o(err_o)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct {
        bit            is_data;
        logic [DW-1:0] rdata;
    } rsp_t;

    rsp_t sb[$];       // expected responses, in order
    bit   src_q[$];    // model: sources of outstanding transactions
    bit   m_hold, m_hold_data, m_last_data, m_err;
    bit   ig_prev, dg_prev;

    // Monitor: each cycle either exactly the expected response or nothing.
    always @(negedge clk) begin
        rsp_t r;
        if (sb.size() > 0) begin
            r = sb.pop_front();
            check("rsp_instr_rvalid", 64'(instr_rvalid_o), 64'(!r.is_data));
            check("rsp_data_rvalid",  64'(data_rvalid_o),  64'(r.is_data));
            check("rsp_instr_rdata",  64'(instr_rdata_o),  64'(r.is_data ? 32'h0 : r.rdata));
            check("rsp_data_rdata",   64'(data_rdata_o),   64'(r.is_data ? r.rdata : 32'h0));
        end else begin
            check("no_rvalid", 64'({instr_rvalid_o, data_rvalid_o}), 64'(0));
        end
    end

    task automatic clear_inputs();
        instr_req_i  = 1'b0; instr_addr_i = '0;
        data_req_i   = 1'b0; data_we_i = 1'b0; data_be_i = '0;
        data_addr_i  = '0;   data_wdata_i = '0;
        mem_gnt_i    = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        src_q.delete();
        m_hold = 1'b0; m_hold_data = 1'b0; m_last_data = 1'b0; m_err = 1'b0;
        ig_prev = 1'b0; dg_prev = 1'b0;
        @(negedge clk);
        check("rst_mem_req", 64'(mem_req_o), 64'(0));
        check("rst_gnt", 64'({instr_gnt_o, data_gnt_o}), 64'(0));
        check("rst_outstanding", 64'(outstanding_o), 64'(0));
        check("rst_err", 64'(err_o), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        bit full, exp_req, win, exp_gnt;
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc % 700 == 699) begin
                do_reset();
                continue;
            end
            // Requesters keep req and payload stable until granted.
            if (!instr_req_i || ig_prev) begin
                instr_req_i  = ($urandom_range(0, 2) != 0);
                instr_addr_i = $urandom;
            end
            if (!data_req_i || dg_prev) begin
                data_req_i   = ($urandom_range(0, 2) != 0);
                data_we_i    = $urandom_range(0, 1) != 0;
                data_be_i    = BW'($urandom);
                data_addr_i  = $urandom;
                data_wdata_i = $urandom;
            end
            // Memory: random grant, in-order responses, occasional stray rvalid.
            mem_gnt_i   = ($urandom_range(0, 2) != 0);
            mem_rdata_i = $urandom;
            if (src_q.size() > 0) mem_rvalid_i = ($urandom_range(0, 2) == 0);
            else                  mem_rvalid_i = ($urandom_range(0, 24) == 0);
            if (mem_rvalid_i && src_q.size() > 0) sb.push_back('{src_q[0], mem_rdata_i});

            @(negedge clk);
            full    = (src_q.size() == MAXO);
            exp_req = 1'b0;
            win     = 1'b0;
            if (m_hold) begin
                exp_req = 1'b1;
                win     = m_hold_data;
            end else if (!full && (instr_req_i || data_req_i)) begin
                exp_req = 1'b1;
                if (instr_req_i && data_req_i) begin
`ifdef OBI_ARB_ROUND_ROBIN_EN
                    win = !m_last_data;
`else
                    win = 1'b1;
`endif
                end else begin
                    win = data_req_i;
                end
            end
            exp_gnt = exp_req && mem_gnt_i;

            check("mem_req", 64'(mem_req_o), 64'(exp_req));
            check("instr_gnt", 64'(instr_gnt_o), 64'(exp_gnt && !win));
            check("data_gnt", 64'(data_gnt_o), 64'(exp_gnt && win));
            check("outstanding", 64'(outstanding_o), 64'(src_q.size()));
            check("err", 64'(err_o), 64'(m_err));
            if (exp_req) begin
                check("mem_addr", 64'(mem_addr_o), 64'(win ? data_addr_i : instr_addr_i));
                check("mem_we", 64'(mem_we_o), 64'(win && data_we_i));
                check("mem_be", 64'(mem_be_o), 64'(win ? data_be_i : 4'hF));
                check("mem_wdata", 64'(mem_wdata_o), 64'(win ? data_wdata_i : 32'h0));
            end

            // Advance the model for the coming clock edge.
            if (mem_rvalid_i) begin
                if (src_q.size() > 0) void'(src_q.pop_front());
                else                  m_err = 1'b1;
            end
            if (exp_gnt) begin
                src_q.push_back(win);
                m_last_data = win;
                m_hold      = 1'b0;
            end else if (exp_req) begin
                m_hold      = 1'b1;
                m_hold_data = win;
            end
            ig_prev = exp_gnt && !win;
            dg_prev = exp_gnt && win;

            @(posedge clk); #1;
        end
        mem_rvalid_i = 1'b0;
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
